countdown_timer: RTL and testbench
==================================

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter WIDTH, default 8: bit width of the counter, load value and reload register.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 enable  input  1  when high, the counter decrements by one per clock while in RUN.
REQ-005 load  input  1  when high, count and reload register capture data_in.
REQ-006 data_in  input  WIDTH  load value.
REQ-007 start  input  1  single-cycle request to begin counting down.
REQ-008 stop  input  1  single-cycle request to abort counting and return to IDLE.
REQ-009 auto_reload  input  1  selects periodic mode when the feature is compiled in.
REQ-010 flag_clr  input  1  clears the sticky flag.
REQ-011 count  output  WIDTH  current counter value.
REQ-012 busy  output  1  high exactly while the state is RUN.
REQ-013 expired  output  1  single-cycle pulse on terminal count.
REQ-014 flag  output  1  sticky terminal-count indicator.

Function
REQ-015 The block SHALL implement three states: IDLE, RUN and EXPIRED; all outputs SHALL be registered.
REQ-016 Command priority SHALL be load > stop > start > decrement.
REQ-017 load in any state SHALL write count <= data_in and reload <= data_in, and SHALL move the state to IDLE on the next edge.
REQ-018 stop in RUN SHALL move the state to IDLE and retain count; in IDLE or EXPIRED, stop SHALL have no effect.
REQ-019 start in IDLE or EXPIRED with count != 0 SHALL move the state to RUN on the next edge; start with count == 0 SHALL be ignored; start in RUN SHALL be ignored.
REQ-020 In RUN with enable high and count > 1, count SHALL decrement by 1 per cycle; with enable low, count SHALL hold and the state SHALL stay RUN.
REQ-021 In RUN with enable high and count == 1 (terminal count), the block SHALL assert expired for exactly the next cycle and set flag.
REQ-022 At terminal count in one-shot mode, count SHALL become 0 and the state SHALL become EXPIRED.
REQ-023 Decrement SHALL never wrap: count SHALL never pass from 0 to all-ones.
REQ-024 flag SHALL stay high until flag_clr; if flag_clr and a terminal count occur in the same cycle, set SHALL win.
REQ-025 The latency from start to the expired pulse SHALL be N+1 cycles for load value N with enable held high (1 cycle to enter RUN, then N decrements).

Reset
REQ-026 Asserting reset_n low SHALL immediately force state IDLE, count 0, reload 0, busy 0, expired 0 and flag 0, independent of clk.
REQ-027 Reset SHALL be deasserted synchronously to clk externally; the first active edge after deassertion SHALL obey REQ-016.
REQ-028 Reset mid-RUN SHALL abort counting with no expired pulse.

Configuration
REQ-029 Macro TIMER_AUTO_RELOAD_EN, when defined: at terminal count with auto_reload high, count SHALL be set to reload and the state SHALL stay RUN (periodic mode).
REQ-030 In periodic mode with reload == 0, the state SHALL go to EXPIRED with count 0.
REQ-031 When TIMER_AUTO_RELOAD_EN is undefined, the auto_reload port SHALL remain present and SHALL be ignored; behaviour SHALL be one-shot only, with no reload register logic beyond load capture.

Verification
REQ-032 Load 3, start, enable=1 -> count sequence 3,2,1,0; expired high for one cycle 4 cycles after start; flag=1; busy falls with expired.
REQ-033 Load 5, start, enable toggled 1,0,0,1 -> count holds at 4 for two cycles, then reads 3; busy stays 1.
REQ-034 Start with count=0 -> state stays IDLE; busy=0; no expired pulse.
REQ-035 RUN at count=2, then load=1 and stop=1 together with data_in=9 -> count=9, IDLE, busy=0.
REQ-036 flag=1, then flag_clr coinciding with a new terminal count -> flag stays 1; flag_clr alone in a later cycle -> flag=0.
REQ-037 With TIMER_AUTO_RELOAD_EN defined: load 2, auto_reload=1, start -> count 2,1,2,1,... with an expired pulse every 2 cycles and busy held 1; reset_n pulsed low mid-count -> count=0 asynchronously, IDLE.

Source files
------------

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - loadable down-counter with one-shot expiry; periodic reload under TIMER_AUTO_RELOAD_EN
module countdown_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             start,
  input  logic             stop,
  input  logic             auto_reload,
  input  logic             flag_clr,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             expired,
  output logic             flag
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_EXPIRED = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic             r_busy;
  logic             r_expired;
  logic             r_flag;
  logic             w_terminal;

`ifdef TIMER_AUTO_RELOAD_EN
  logic [WIDTH-1:0] r_reload;
`else
  // One-shot build: auto_reload stays on the port list but drives nothing.
  logic             w_unused_auto_reload;
  assign w_unused_auto_reload = auto_reload;
`endif

  // Terminal count: a decrement from 1 that is not pre-empted by load or stop.
  assign w_terminal = (r_state == ST_RUN) && enable && !load && !stop &&
                      (r_count == WIDTH'(1));

  // Sticky flag: a terminal count beats a simultaneous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_flag <= 1'b0;
    end else if (w_terminal) begin
      r_flag <= 1'b1;
    end else if (flag_clr) begin
      r_flag <= 1'b0;
    end
  end

`ifdef TIMER_AUTO_RELOAD_EN
  // Reload value follows every load so periodic mode restarts from it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_reload <= '0;
    end else if (load) begin
      r_reload <= data_in;
    end
  end
`endif

  // Main control FSM: load > stop > start > decrement.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_count   <= '0;
      r_busy    <= 1'b0;
      r_expired <= 1'b0;
    end else begin
      r_expired <= w_terminal;
      if (load) begin
        r_count <= data_in;
        r_state <= ST_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          ST_RUN: begin
            if (stop) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else if (enable) begin
              if (r_count > WIDTH'(1)) begin
                r_count <= r_count - WIDTH'(1);
              end else begin
`ifdef TIMER_AUTO_RELOAD_EN
                if (auto_reload && (r_reload != '0)) begin
                  r_count <= r_reload;
                end else
`endif
                begin
                  // Also covers a zero count in RUN: park at 0 rather than wrap.
                  r_count <= '0;
                  r_state <= ST_EXPIRED;
                  r_busy  <= 1'b0;
                end
              end
            end
          end
          default: begin
            if (start && (r_count != '0)) begin
              r_state <= ST_RUN;
              r_busy  <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign count   = r_count;
  assign busy    = r_busy;
  assign expired = r_expired;
  assign flag    = r_flag;

endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - random and directed checks of countdown_timer against a behavioural model
module tb_countdown_timer;

  localparam int W = 8;

  logic         clk         = 1'b0;
  logic         reset_n     = 1'b0;
  logic         enable      = 1'b0;
  logic         load        = 1'b0;
  logic         start       = 1'b0;
  logic         stop        = 1'b0;
  logic         auto_reload = 1'b0;
  logic         flag_clr    = 1'b0;
  logic [W-1:0] data_in     = '0;
  logic [W-1:0] count;
  logic         busy;
  logic         expired;
  logic         flag;

  countdown_timer #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .load        (load),
    .data_in     (data_in),
    .start       (start),
    .stop        (stop),
    .auto_reload (auto_reload),
    .flag_clr    (flag_clr),
    .count       (count),
    .busy        (busy),
    .expired     (expired),
    .flag        (flag)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: "counting" is true while the timer is running; value is plain int arithmetic.
  int m_value    = 0;
  int m_period   = 0;
  bit m_counting = 0;
  bit m_pulse    = 0;
  bit m_sticky   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_value    = 0;
    m_period   = 0;
    m_counting = 0;
    m_pulse    = 0;
    m_sticky   = 0;
  endtask

  task automatic model_edge();
    bit hit;
    hit = 0;
    if (!reset_n) begin
      model_reset();
      return;
    end
    if (load) begin
      m_value    = int'(data_in);
      m_period   = int'(data_in);
      m_counting = 0;
    end else if (m_counting && stop) begin
      m_counting = 0;
    end else if (!m_counting) begin
      if (start && m_value != 0) m_counting = 1;
    end else if (enable) begin
      if (m_value >= 2) begin
        m_value = m_value - 1;
      end else begin
        hit = (m_value == 1);
        m_value = 0;
        m_counting = 0;
`ifdef TIMER_AUTO_RELOAD_EN
        if (auto_reload && m_period != 0) begin
          m_value = m_period;
          m_counting = 1;
        end
`endif
      end
    end
    m_pulse = hit;
    if (hit) m_sticky = 1;
    else if (flag_clr) m_sticky = 0;
  endtask

  task automatic compare_all();
    check("count", int'(count), m_value);
    check("busy", int'(busy), int'(m_counting));
    check("expired", int'(expired), int'(m_pulse));
    check("flag", int'(flag), int'(m_sticky));
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    model_edge();
    compare_all();
  endtask

  initial begin
    // Reset state
    reset_n = 1'b0;
    cycle();
    check("rst_count", int'(count), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_flag", int'(flag), 0);
    reset_n = 1'b1;

    // Load 3, start, enable high: 3,2,1,0 with expiry 4 cycles after start
    load = 1'b1; data_in = 8'd3; cycle(); load = 1'b0;
    start = 1'b1; enable = 1'b1; cycle(); start = 1'b0;
    check("t32_start_count", int'(count), 3);
    check("t32_start_busy", int'(busy), 1);
    cycle(); check("t32_c2", int'(count), 2);
    cycle(); check("t32_c1", int'(count), 1);
    check("t32_no_exp_early", int'(expired), 0);
    cycle();
    check("t32_c0", int'(count), 0);
    check("t32_expired", int'(expired), 1);
    check("t32_busy_fall", int'(busy), 0);
    check("t32_flag", int'(flag), 1);
    cycle(); check("t32_pulse_one", int'(expired), 0);

    // Enable pattern 1,0,0,1 from 5
    load = 1'b1; data_in = 8'd5; cycle(); load = 1'b0;
    start = 1'b1; cycle(); start = 1'b0;
    cycle(); check("t33_c4", int'(count), 4);
    enable = 1'b0; cycle(); check("t33_hold_a", int'(count), 4);
    cycle(); check("t33_hold_b", int'(count), 4);
    check("t33_busy_hold", int'(busy), 1);
    enable = 1'b1; cycle(); check("t33_c3", int'(count), 3);

    // Load and stop together mid-run
    cycle(); check("t35_c2", int'(count), 2);
    load = 1'b1; stop = 1'b1; data_in = 8'd9; cycle(); load = 1'b0; stop = 1'b0;
    check("t35_count", int'(count), 9);
    check("t35_busy", int'(busy), 0);

    // Start with zero count is ignored
    load = 1'b1; data_in = 8'd0; cycle(); load = 1'b0;
    start = 1'b1; cycle(); start = 1'b0;
    check("t34_busy", int'(busy), 0);
    cycle(); check("t34_no_exp", int'(expired), 0);

    // Flag set beats a simultaneous clear; clear alone afterwards
    load = 1'b1; data_in = 8'd1; cycle(); load = 1'b0;
    start = 1'b1; cycle(); start = 1'b0;
    flag_clr = 1'b1; cycle(); flag_clr = 1'b0;
    check("t36_exp", int'(expired), 1);
    check("t36_flag_kept", int'(flag), 1);
    flag_clr = 1'b1; cycle(); flag_clr = 1'b0;
    check("t36_flag_clr", int'(flag), 0);

    // Asynchronous reset mid-run
    load = 1'b1; data_in = 8'd5; cycle(); load = 1'b0;
    start = 1'b1; cycle(); start = 1'b0;
    cycle(); cycle();
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check("arst_count", int'(count), 0);
    check("arst_busy", int'(busy), 0);
    compare_all();
    cycle();
    reset_n = 1'b1;
    cycle();

`ifdef TIMER_AUTO_RELOAD_EN
    // Periodic mode: 2,1,2,1 with a pulse every second cycle
    load = 1'b1; data_in = 8'd2; cycle(); load = 1'b0;
    auto_reload = 1'b1; enable = 1'b1;
    start = 1'b1; cycle(); start = 1'b0;
    check("ar_c2a", int'(count), 2);
    cycle(); check("ar_c1a", int'(count), 1);
    cycle(); check("ar_c2b", int'(count), 2);
    check("ar_exp", int'(expired), 1);
    check("ar_busy", int'(busy), 1);
    cycle(); check("ar_c1b", int'(count), 1);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check("ar_rst_count", int'(count), 0);
    check("ar_rst_busy", int'(busy), 0);
    cycle();
    reset_n = 1'b1;
`endif

    // Random stimulus
    for (int i = 0; i < 3000; i++) begin
      load        = ($urandom_range(0, 15) == 0);
      stop        = ($urandom_range(0, 15) == 0);
      start       = ($urandom_range(0, 5) == 0);
      enable      = ($urandom_range(0, 3) != 0);
      flag_clr    = ($urandom_range(0, 7) == 0);
      auto_reload = $urandom_range(0, 1);
      data_in     = ($urandom_range(0, 9) == 0) ? W'($urandom) : W'($urandom_range(0, 6));
      reset_n     = ($urandom_range(0, 299) != 0);
      cycle();
    end
    reset_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
